// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clk_div_gen divider bank.
// Optional feature macro: CLK_DIV_TICK_EN (see clk_div_channel).
package clk_div_pkg;

  localparam int unsigned DIV_W_DEF       = 16;
  localparam int unsigned DEFAULT_DIV_DEF = 5;
  localparam int unsigned MAX_CH          = 8;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/pending divisor and square-wave output.
// Macro CLK_DIV_TICK_EN: when defined, a registered rising-edge tick is built;
// otherwise tick is tied low and no tick register exists.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_val,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] div_cur
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] n_act;
  logic [DIV_W-1:0] p_div;
  logic             pf;
  logic             clk_q;

  logic [DIV_W-1:0] wr_fix;
  logic [DIV_W-1:0] p_eff;
  logic             pf_eff;
  logic             wrap;
  logic             commit;

  // Same-cycle writes are folded in before the commit decision so a write
  // landing on a wrap/sync/disabled edge takes effect on that very edge.
  always_comb begin
    wr_fix = (wr_val == '0) ? DIV_W'(1) : wr_val;
    p_eff  = wr ? wr_fix : p_div;
    pf_eff = wr | pf;
    wrap   = (cnt == n_act - DIV_W'(1));
    commit = pf_eff && (sync || !en || wrap);
  end

  // Divisor bookkeeping, counter and output toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      n_act <= DIV_W'(DEFAULT_DIV);
      p_div <= DIV_W'(DEFAULT_DIV);
      pf    <= 1'b0;
      clk_q <= 1'b0;
    end else begin
      p_div <= p_eff;
      pf    <= pf_eff && !commit;
      if (commit) n_act <= p_eff;
      if (sync || !en) begin
        cnt   <= '0;
        clk_q <= 1'b0;
      end else begin
        cnt <= wrap ? '0 : cnt + DIV_W'(1);
        if (cnt == '0) clk_q <= ~clk_q;
      end
    end
  end

  assign clk_out = clk_q;
  assign div_cur = n_act;

`ifdef CLK_DIV_TICK_EN
  logic tick_q;

  // Tick marks the edge on which clk_out goes from 0 to 1.
  always_ff @(posedge clk) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= en && !sync && (cnt == '0) && !clk_q;
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/clk_div_gen.sv
// Bank of NUM_CH independent programmable clock dividers with common sync.
// Macro CLK_DIV_TICK_EN enables the per-channel tick outputs.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          en,
  input  logic                       sync,
  input  logic                       div_wr,
  input  logic [ch_idx_w(NUM_CH)-1:0] div_ch,
  input  logic [DIV_W-1:0]           div_val,
  output logic [NUM_CH-1:0]          clk_out,
  output logic [NUM_CH-1:0]          tick,
  output logic [NUM_CH*DIV_W-1:0]    div_cur
);

  localparam int unsigned CH_W = ch_idx_w(NUM_CH);

  // Out-of-range channel indices match no instance and are dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(g);
    logic wr_sel;
    assign wr_sel = div_wr && (div_ch == IDX);

    clk_div_channel #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en[g]),
      .sync   (sync),
      .wr     (wr_sel),
      .wr_val (div_val),
      .clk_out(clk_out[g]),
      .tick   (tick[g]),
      .div_cur(div_cur[g*DIV_W +: DIV_W])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Randomized self-checking bench for clk_div_gen (3 channels, 8-bit divisors).
module tb_clk_div_gen;

  localparam int unsigned NCH = 3;
  localparam int unsigned DW  = 8;
  localparam int unsigned DEF = 5;
`ifdef CLK_DIV_TICK_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    en;
  logic              sync;
  logic              div_wr;
  logic [1:0]        div_ch;
  logic [DW-1:0]     div_val;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    tick;
  logic [NCH*DW-1:0] div_cur;

  clk_div_gen #(
    .NUM_CH     (NCH),
    .DIV_W      (DW),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sync   (sync),
    .div_wr (div_wr),
    .div_ch (div_ch),
    .div_val(div_val),
    .clk_out(clk_out),
    .tick   (tick),
    .div_cur(div_cur)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Reference model: position within the current half-period, divisors, output level.
  int unsigned m_pos [NCH];
  int unsigned m_n   [NCH];
  int unsigned m_p   [NCH];
  bit          m_pf  [NCH];
  bit          m_lvl [NCH];
  bit          m_tick[NCH];

  task automatic model_edge(input bit r, input logic [NCH-1:0] e, input bit s,
                            input bit w, input int unsigned ch, input int unsigned v);
    for (int unsigned c = 0; c < NCH; c++) begin
      if (r) begin
        m_pos[c] = 0; m_n[c] = DEF; m_p[c] = DEF; m_pf[c] = 0;
        m_lvl[c] = 0; m_tick[c] = 0;
      end else begin
        bit last;
        if (w && ch == c) begin
          m_p[c] = (v == 0) ? 1 : v;
          m_pf[c] = 1;
        end
        last = (m_pos[c] + 1 == m_n[c]);
        if (s || !e[c]) begin
          m_pos[c] = 0; m_lvl[c] = 0; m_tick[c] = 0;
          if (m_pf[c]) begin m_n[c] = m_p[c]; m_pf[c] = 0; end
        end else begin
          m_tick[c] = (m_pos[c] == 0) && !m_lvl[c];
          if (m_pos[c] == 0) m_lvl[c] = !m_lvl[c];
          if (last) begin
            m_pos[c] = 0;
            if (m_pf[c]) begin m_n[c] = m_p[c]; m_pf[c] = 0; end
          end else m_pos[c]++;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input logic [NCH-1:0] e, input bit s,
                     input bit w, input logic [1:0] ch, input logic [DW-1:0] v);
    logic [NCH-1:0]    x_clk;
    logic [NCH-1:0]    x_tick;
    logic [NCH*DW-1:0] x_div;
    rst = r; en = e; sync = s; div_wr = w; div_ch = ch; div_val = v;
    @(posedge clk);
    model_edge(r, e, s, w, int'(ch), int'(v));
    #1;
    for (int unsigned c = 0; c < NCH; c++) begin
      x_clk[c]         = m_lvl[c];
      x_tick[c]        = m_tick[c] & TICK_ON;
      x_div[c*DW +: DW] = DW'(m_n[c]);
    end
    chk("clk_out", 64'(clk_out), 64'(x_clk));
    chk("tick", 64'(tick), 64'(x_tick));
    chk("div_cur", 64'(div_cur), 64'(x_div));
  endtask

  task automatic idle(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) cyc(0, '1, 0, 0, 2'd0, '0);
  endtask

  initial begin
    logic [NCH*DW-1:0] saved;
    logic              a;
    int unsigned       guard;

    // Reset dominates en, sync and a pending write in the same cycle.
    cyc(1, '1, 1, 1, 2'd0, 8'd9);
    cyc(1, '1, 1, 1, 2'd1, 8'd3);
    chk("rst_div", 64'(div_cur), 64'({8'd5, 8'd5, 8'd5}));
    chk("rst_clk", 64'(clk_out), 64'd0);

    // Default divisor 5: high cycles 1-5, low 6-10, tick at 1, 11, 21.
    for (int unsigned k = 1; k <= 21; k++) begin
      cyc(0, '1, 0, 0, 2'd0, '0);
      chk("div5_clk", 64'(clk_out[0]), 64'(((k - 1) % 10) < 5));
      chk("div5_tick", 64'(tick[0]), 64'(TICK_ON && ((k - 1) % 10 == 0)));
    end

    // Divisor change mid half-period: write 2 while the counter sits at 2.
    guard = 0;
    while (m_pos[0] != 2 && guard < 40) begin idle(1); guard++; end
    chk("wait_pos2", 64'(guard < 40), 64'd1);
    cyc(0, '1, 0, 1, 2'd0, 8'd2);
    chk("div_hold", 64'(div_cur[7:0]), 64'd5);
    idle(12);
    chk("div_new2", 64'(div_cur[7:0]), 64'd2);

    // Divisor 0 is stored as 1 and toggles every cycle.
    cyc(0, '1, 0, 1, 2'd1, 8'd0);
    idle(12);
    chk("div0_as1", 64'(div_cur[15:8]), 64'd1);
    a = clk_out[1];
    idle(1);
    chk("div1_toggle", 64'(clk_out[1]), 64'(!a));

    // Phase alignment: ch0 N=3, ch1 N=4, then sync.
    cyc(0, '1, 0, 1, 2'd0, 8'd3);
    cyc(0, '1, 0, 1, 2'd1, 8'd4);
    idle(7);
    cyc(0, '1, 1, 0, 2'd0, '0);
    chk("sync_low", 64'(clk_out[1:0]), 64'd0);
    chk("sync_div", 64'(div_cur[15:0]), 64'({8'd4, 8'd3}));
    idle(1);
    chk("sync_rise", 64'(clk_out[1:0]), 64'd3);
    chk("sync_tick", 64'(tick[1:0]), TICK_ON ? 64'd3 : 64'd0);

    // Out-of-range channel index is ignored.
    saved = div_cur;
    cyc(0, '1, 0, 1, 2'd3, 8'd7);
    idle(30);
    chk("bad_ch", 64'(div_cur), 64'(saved));

    // Enable dropped during the high phase, then restored.
    guard = 0;
    while (!(m_lvl[0] && m_pos[0] != 0) && guard < 40) begin idle(1); guard++; end
    chk("wait_high", 64'(guard < 40), 64'd1);
    cyc(0, 3'b110, 0, 0, 2'd0, '0);
    chk("en_off", 64'(clk_out[0]), 64'd0);
    cyc(0, 3'b111, 0, 0, 2'd0, '0);
    chk("en_on", 64'(clk_out[0]), 64'd1);
    chk("en_on_tick", 64'(tick[0]), 64'(TICK_ON));

    // Randomized traffic against the model.
    for (int unsigned i = 0; i < 500; i++) begin
      logic [NCH-1:0] e;
      for (int unsigned c = 0; c < NCH; c++) e[c] = ($urandom_range(0, 7) != 0);
      cyc(($urandom_range(0, 63) == 0), e, ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
          8'($urandom_range(0, 7)));
    end

    // Reset with pending write and sync together.
    cyc(0, '1, 0, 1, 2'd2, 8'd6);
    cyc(1, '1, 1, 1, 2'd0, 8'd2);
    chk("rst2_div", 64'(div_cur), 64'({8'd5, 8'd5, 8'd5}));
    chk("rst2_tick", 64'(tick), 64'd0);
    idle(25);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
